// File: rtl/quesadilla.sv
// Instruction-fetch stage: a 32-bit program counter that advances by 4 every
// clock and a constant instruction ROM read asynchronously at the current PC.
module quesadilla #(
  parameter int MEM_DEPTH = 64,
  parameter int ADDR_BITS = 6
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] current_pc_out,
  output logic [31:0] next_pc_out,
  output logic [31:0] instruction_out
);

  logic [31:0]          r_pc;
  logic [31:0]          w_next_pc;
  logic [ADDR_BITS-1:0] w_idx;

  // Fixed program; every word past the listed ones is a NOP (addi x0,x0,0).
  function automatic logic [31:0] rom_word(input logic [ADDR_BITS-1:0] idx);
    logic [31:0] word;
    case (idx)
      ADDR_BITS'(0): word = 32'h0050_0093;
      ADDR_BITS'(1): word = 32'h00A0_0113;
      ADDR_BITS'(2): word = 32'h0020_81B3;
      ADDR_BITS'(3): word = 32'h4011_0233;
      ADDR_BITS'(4): word = 32'h0020_F2B3;
      ADDR_BITS'(5): word = 32'h0020_E333;
      ADDR_BITS'(6): word = 32'h0000_0013;
      ADDR_BITS'(7): word = 32'h0000_006F;
      default:       word = 32'h0000_0013;
    endcase
    return word;
  endfunction

  // Upper PC bits are dropped, so fetches alias every MEM_DEPTH*4 bytes.
  assign w_next_pc = r_pc + 32'd4;
  assign w_idx     = r_pc[ADDR_BITS+1:2];

  always_ff @(posedge clk) begin
    if (!reset) r_pc <= 32'h0000_0000;
    else        r_pc <= w_next_pc;
  end

  assign current_pc_out  = r_pc;
  assign next_pc_out     = w_next_pc;
  assign instruction_out = rom_word(w_idx);

endmodule

// File: tb/tb_quesadilla.sv
// Scoreboard bench for quesadilla: the driver pushes the expected fetch state
// for every clock edge, and a monitor compares it after the edge.
module tb_quesadilla;

  localparam int MEM_DEPTH = 64;
  localparam int ADDR_BITS = 6;

  logic        clk;
  logic        reset;
  logic [31:0] current_pc_out;
  logic [31:0] next_pc_out;
  logic [31:0] instruction_out;

  quesadilla #(.MEM_DEPTH(MEM_DEPTH), .ADDR_BITS(ADDR_BITS)) dut (
    .clk             (clk),
    .reset           (reset),
    .current_pc_out  (current_pc_out),
    .next_pc_out     (next_pc_out),
    .instruction_out (instruction_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_pc;

  logic [31:0] prog [8] = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h40110233,
                            32'h0020F2B3, 32'h0020E333, 32'h00000013, 32'h0000006F};

  function automatic logic [31:0] model_instr(input logic [31:0] pc);
    int unsigned word;
    word = (pc / 4) % MEM_DEPTH;
    if (word < 8) return prog[word];
    return 32'h00000013;
  endfunction

  function automatic exp_t model_state(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.npc   = pc + 32'd4;
    e.instr = model_instr(pc);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (model pc %08h)", name, act, req, m_pc);
    end
  endtask

  // One clock edge with the given reset level; model the resulting PC.
  task automatic step(input logic rst_n);
    @(negedge clk);
    reset = rst_n;
    m_pc  = rst_n ? m_pc + 32'd4 : 32'h0;
    sb_q.push_back(model_state(m_pc));
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("pc",    current_pc_out,  e.pc);
      check("npc",   next_pc_out,     e.npc);
      check("instr", instruction_out, e.instr);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    reset = 1'b1;
    m_pc  = 32'h0;
    repeat (2) @(posedge clk);

    repeat (2) step(1'b0);

    // Sequential fetch, fill region and aliasing past 0x100 up to 0x104.
    guard = 0;
    while (m_pc != 32'h104 && guard < 200) begin
      step(1'b1);
      guard++;
    end
    check("reach_alias", m_pc, 32'h104);

    // Run to 0x14 again via reset, then a single-edge mid-run reset.
    step(1'b0);
    guard = 0;
    while (m_pc != 32'h14 && guard < 200) begin
      step(1'b1);
      guard++;
    end
    step(1'b0);
    step(1'b1);
    step(1'b1);

    // Randomized reset pulses.
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1);
    step(1'b1);

    // 32-bit wrap: load the PC directly just after an edge.
    @(posedge clk);
    #2;
    force dut.r_pc = 32'hFFFFFFFC;
    #1;
    m_pc = 32'hFFFFFFFC;
    check("wrap_pc",    current_pc_out,  32'hFFFFFFFC);
    check("wrap_npc",   next_pc_out,     32'h00000000);
    check("wrap_instr", instruction_out, model_instr(32'hFFFFFFFC));
    release dut.r_pc;
    step(1'b1);
    step(1'b1);

    guard = 0;
    while (sb_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
